// File: rtl/shift_pkg.sv
// Shared definitions for the sequential shift units: FSM encoding and default sizes.
package shift_pkg;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_STEP  = 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   // Largest per-cycle shift that can ever be requested; the amount never reaches WIDTH.
   function automatic int step_clamp(input int step, input int width);
      return (step >= width) ? width - 1 : step;
   endfunction

endpackage

// File: rtl/sll_step.sv
// One combinational iteration of the left shift: moves min(STEP, rem) bits per call.
// The shifted-out OR output exists only when SLL_SEQ_OVF_EN is defined.
module sll_step
   import shift_pkg::*;
#(
   parameter  int WIDTH = DEF_WIDTH,
   parameter  int STEP  = DEF_STEP,
   localparam int SHW   = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] data_i,
   input  logic [SHW-1:0]   rem_i,
   output logic [WIDTH-1:0] data_o,
   output logic [SHW-1:0]   rem_o
`ifdef SLL_SEQ_OVF_EN
   ,
   output logic             out_or_o
`endif
);

   localparam int             KMAX   = step_clamp(STEP, WIDTH);
   localparam logic [SHW-1:0] KMAX_W = SHW'(KMAX);

   logic [SHW-1:0] k;

   always_comb begin
      k      = (rem_i < KMAX_W) ? rem_i : KMAX_W;
      data_o = data_i << k;
      rem_o  = rem_i - k;
   end

`ifdef SLL_SEQ_OVF_EN
   // Only the top k bits leave the word this cycle.
   always_comb begin
      out_or_o = 1'b0;
      for (int i = 0; i < KMAX; i++) begin
         if (SHW'(i) < k) begin
            out_or_o = out_or_o | data_i[WIDTH-1-i];
         end
      end
   end
`endif

endmodule

// File: rtl/sll_seq.sv
// Multi-cycle logical shift-left unit: STEP bits per cycle, result held until consumed.
// Define SLL_SEQ_OVF_EN to accumulate the shifted-out flag on ovf; otherwise ovf is 0.
module sll_seq
   import shift_pkg::*;
#(
   parameter  int WIDTH = DEF_WIDTH,
   parameter  int STEP  = DEF_STEP,
   localparam int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [SHW-1:0]   shamt,
   input  logic             use_imm,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             ovf,
   output logic             busy
);

   // Handshake: a request transfers on a rising edge where in_valid && in_ready; a result
   // transfers where out_valid && out_ready. in_ready is high only in IDLE, out_valid only
   // in DONE, so the two never overlap and the DONE->IDLE edge cannot also accept.

   state_e           state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [SHW-1:0]   rem_q, rem_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;
   logic             busy_q, busy_d;
   logic [SHW-1:0]   amount;
   logic [WIDTH-1:0] step_data;
   logic [SHW-1:0]   step_rem;
`ifdef SLL_SEQ_OVF_EN
   logic             ovf_q, ovf_d;
   logic             step_or;
`endif

   logic unused_b_hi;
   assign unused_b_hi = ^b[WIDTH-1:SHW];

   sll_step #(
      .WIDTH (WIDTH),
      .STEP  (STEP)
   ) u_step (
      .data_i   (data_q),
      .rem_i    (rem_q),
      .data_o   (step_data),
      .rem_o    (step_rem)
`ifdef SLL_SEQ_OVF_EN
      ,
      .out_or_o (step_or)
`endif
   );

   always_comb begin
      amount  = use_imm ? shamt : b[SHW-1:0];
      state_d = state_q;
      data_d  = data_q;
      rem_d   = rem_q;
`ifdef SLL_SEQ_OVF_EN
      ovf_d   = ovf_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (in_valid && in_ready_q) begin
               data_d  = a;
               rem_d   = amount;
`ifdef SLL_SEQ_OVF_EN
               ovf_d   = 1'b0;
`endif
               state_d = (amount == '0) ? ST_DONE : ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            data_d = step_data;
            rem_d  = step_rem;
`ifdef SLL_SEQ_OVF_EN
            ovf_d  = ovf_q | step_or;
`endif
            if (step_rem == '0) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // Status outputs are registered from the next state so they line up with state_q.
      in_ready_d  = (state_d == ST_IDLE);
      out_valid_d = (state_d == ST_DONE);
      busy_d      = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         data_q      <= '0;
         rem_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
`ifdef SLL_SEQ_OVF_EN
         ovf_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         data_q      <= data_d;
         rem_q       <= rem_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
`ifdef SLL_SEQ_OVF_EN
         ovf_q       <= ovf_d;
`endif
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign out       = data_q;
`ifdef SLL_SEQ_OVF_EN
   assign ovf       = ovf_q;
`else
   assign ovf       = 1'b0;
`endif

endmodule
